// File: rtl/mult_booth_param.sv
// Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> {hi,lo}, signed or unsigned per operation.
// Result and pronto WIDTH+2 edges after comeco; comeco is ignored while busy, so there is no queueing.
module mult_booth_param #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             comeco,
  input  logic             sinal,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             pronto
);

  localparam int E  = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {ESPERA, REPETICAO, FIM} state_t;

  state_t         state, state_nxt;
  logic [E-1:0]   mcand;
  logic [2*E:0]   acc;
  logic [CW-1:0]  count;
  logic [E-1:0]   a_ext, b_ext, p_sum;
  logic [2*E:0]   acc_step;

  // One extra bit lets unsigned operands run through the signed Booth recoding unchanged.
  always_comb begin
    a_ext = {sinal & a[WIDTH-1], a};
    b_ext = {sinal & b[WIDTH-1], b};
    p_sum = acc[2*E:E+1];
    case (acc[1:0])
      2'b01:   p_sum = acc[2*E:E+1] + mcand;
      2'b10:   p_sum = acc[2*E:E+1] - mcand;
      default: p_sum = acc[2*E:E+1];
    endcase
    acc_step = {p_sum[E-1], p_sum, acc[E:1]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ESPERA;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ESPERA:    if (comeco) state_nxt = REPETICAO;
      REPETICAO: if (count == CW'(E - 1)) state_nxt = FIM;
      FIM:       state_nxt = ESPERA;
      default:   state_nxt = ESPERA;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      acc    <= '0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      pronto <= 1'b0;
    end else begin
      case (state)
        ESPERA: begin
          pronto <= 1'b0;
          if (comeco) begin
            mcand <= a_ext;
            acc   <= {{E{1'b0}}, b_ext, 1'b0};
            count <= '0;
            busy  <= 1'b1;
          end
        end
        REPETICAO: begin
          acc   <= acc_step;
          count <= count + CW'(1);
        end
        FIM: begin
          hi     <= acc[2*WIDTH:WIDTH+1];
          lo     <= acc[WIDTH:1];
          pronto <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth_param.sv
// Bench for mult_booth_param: directed corners at WIDTH=32, random operands at WIDTH=32 and WIDTH=8.
module tb_mult_booth_param;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        c32 = 1'b0, s32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, hi32, lo32;
  logic        busy32, pr32;
  logic        c8 = 1'b0, s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, hi8, lo8;
  logic        busy8, pr8;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] prev32 = '0;
  logic [15:0] prev8 = '0;

  always #5 clock = ~clock;

  mult_booth_param #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .comeco(c32), .sinal(s32), .a(a32), .b(b32),
    .hi(hi32), .lo(lo32), .busy(busy32), .pronto(pr32)
  );

  mult_booth_param #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .comeco(c8), .sinal(s8), .a(a8), .b(b8),
    .hi(hi8), .lo(lo8), .busy(busy8), .pronto(pr8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: sign- or zero-extend to 64 bits, multiply mod 2^64, keep 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic s,
                                           input logic [63:0] x, input logic [63:0] y);
    logic [63:0] xe, ye, mask;
    mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    xe = x;
    ye = y;
    if (s) begin
      for (int i = w; i < 64; i++) begin
        xe[i] = x[w-1];
        ye[i] = y[w-1];
      end
    end
    return (xe * ye) & mask;
  endfunction

  task automatic drive(input int w, input logic go, input logic s,
                       input logic [63:0] x, input logic [63:0] y);
    if (w == 32) begin
      c32 = go; s32 = s; a32 = x[31:0]; b32 = y[31:0];
    end else begin
      c8 = go; s8 = s; a8 = x[7:0]; b8 = y[7:0];
    end
  endtask

  task automatic sample(input int w, output logic [63:0] prod, output logic bz, output logic pr);
    if (w == 32) begin
      prod = {hi32, lo32}; bz = busy32; pr = pr32;
    end else begin
      prod = {48'b0, hi8, lo8}; bz = busy8; pr = pr8;
    end
  endtask

  // Called #1 after a rising edge; leaves the bench #1 after the edge that raised pronto.
  task automatic run_op(input int w, input logic s, input logic [63:0] xi,
                        input logic [63:0] yi, input int repulse);
    logic [63:0] x, y, opmask, exp, prod, prevp;
    logic        bz, pr;
    int          n;
    opmask = (64'd1 << w) - 64'd1;
    x      = xi & opmask;
    y      = yi & opmask;
    exp    = ref_prod(w, s, x, y);
    prevp  = (w == 32) ? prev32 : {48'b0, prev8};
    drive(w, 1'b1, s, x, y);
    @(posedge clock); #1;
    drive(w, 1'b0, ~s, ~x, ~y);
    sample(w, prod, bz, pr);
    check("busy_start", {63'b0, bz}, 64'd1);
    check("pronto_low_at_start", {63'b0, pr}, 64'd0);
    n = 0;
    while (n < 3 * w) begin
      @(posedge clock); #1;
      n++;
      sample(w, prod, bz, pr);
      if (pr) break;
      if (n == 2) check("hold_prev_result", prod, prevp);
      if (repulse > 0 && n == repulse) drive(w, 1'b1, ~s, ~x, ~y);
      else if (repulse > 0 && n == repulse + 1) drive(w, 1'b0, s, x, y);
    end
    check("latency", 64'(n), 64'(w + 2));
    check("product", prod, exp);
    check("busy_done", {63'b0, bz}, 64'd0);
    if (w == 32) prev32 = prod;
    else         prev8  = prod[15:0];
    if (repulse > 0) begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clock); #1;
        sample(w, prod, bz, pr);
        check("single_pronto", {62'b0, pr, bz}, 64'd0);
      end
    end
  endtask

  initial begin
    logic [63:0] prod;
    logic        bz, pr;

    #12;
    sample(32, prod, bz, pr);
    check("reset_prod", prod, 64'd0);
    check("reset_flags", {62'b0, bz, pr}, 64'd0);
    #10 reset = 1'b1;
    @(posedge clock); #1;

    run_op(32, 1'b1, 64'd7, 64'hFFFF_FFFD, 0);
    check("dir_7x-3", prev32, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(32, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0);
    check("dir_unsigned_ff", prev32, 64'hFFFF_FFFE_0000_0001);
    run_op(32, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0);
    check("dir_signed_ff", prev32, 64'd1);
    run_op(32, 1'b1, 64'h8000_0000, 64'h8000_0000, 0);
    check("dir_min_min", prev32, 64'h4000_0000_0000_0000);
    run_op(32, 1'b1, 64'd0, 64'(32'($urandom)), 0);
    run_op(32, 1'b0, 64'd5, 64'd6, 5);
    check("dir_repulse", prev32, 64'd30);

    // Abort mid-operation: outputs must clear asynchronously, without waiting for an edge.
    drive(32, 1'b1, 1'b1, 64'd123, 64'd456);
    @(posedge clock); #1;
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (9) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    sample(32, prod, bz, pr);
    check("abort_prod", prod, 64'd0);
    check("abort_flags", {62'b0, bz, pr}, 64'd0);
    prev32 = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      sample(32, prod, bz, pr);
      check("abort_no_pronto", {63'b0, pr}, 64'd0);
    end
    #2 reset = 1'b1;
    @(posedge clock); #1;
    run_op(32, 1'b1, 64'hFFFF_FFF9, 64'd11, 0);

    for (int i = 0; i < 20; i++)
      run_op(32, 1'($urandom_range(0, 1)), 64'($urandom), 64'($urandom), 0);

    run_op(8, 1'b1, 64'h80, 64'h80, 0);
    run_op(8, 1'b0, 64'hFF, 64'hFF, 0);
    for (int i = 0; i < 1000; i++)
      run_op(8, 1'($urandom_range(0, 1)), 64'($urandom), 64'($urandom), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
